// File: rtl/pong_pkg.sv
// pong_pkg: shared constants, scan FSM state encoding and the paddle clamp helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  localparam int ADC_W = 9;
  localparam int Y_W   = 10;

  // Paddle position restored by reset: mid-screen.
  localparam logic [Y_W-1:0] DEFAULT_Y = 10'd240;

  // Default largest legal paddle Y; the controller takes its own Y_MAX parameter.
  localparam int Y_MAX_DEF = 479;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4
  } scan_state_e;

  // Saturate an ADC code to the legal paddle range and widen to a Y coordinate.
  function automatic logic [Y_W-1:0] clamp_y(input logic [ADC_W-1:0] code,
                                            input logic [ADC_W-1:0] y_max);
    return (code > y_max) ? {1'b0, y_max} : {1'b0, code};
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// cyc_timer: loadable down-counter that parks at zero and flags it.
// Latency: load takes effect on the next edge; zero_o is combinational from the count.
// Backpressure: none; load_i has priority over counting.
module cyc_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Reload while the owner is outside its timed state, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sequences the shared 9-bit paddle ADC and its 2:1 mux, storing clamped Y per player.
// Latency: tick to upd = 2*(SETTLE_CYC+1+D+1)+1 cycles for ADC done delay D (ADC_AVG_EN: 4 conversions/channel).
// Backpressure: none; ticks during a scan are dropped, en only gates new scans. Optional feature macro: ADC_AVG_EN.
module adc_scan_ctrl
  import pong_pkg::*;
#(
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 4096,
  parameter int SCAN_PERIOD = 262144,
  parameter int Y_MAX       = Y_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_done,
  output logic             sel,
  output logic             adc_start,
  output logic [Y_W-1:0]   p1_y,
  output logic [Y_W-1:0]   p2_y,
  output logic             upd,
  output logic             timeout_err
);

  localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0]    PERIOD_LAST  = PW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0]    SETTLE_LOAD  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]    TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADC_W-1:0] Y_LIM        = ADC_W'(Y_MAX);

  scan_state_e      state_q;
  logic             ch_q;
  logic             sel_q;
  logic             start_q;
  logic             upd_q;
  logic             err_q;
  logic [Y_W-1:0]   p1_q;
  logic [Y_W-1:0]   p2_q;
  logic [PW-1:0]    period_q;
  logic             tick;
  logic             settle_done;
  logic             wait_expired;
  logic [ADC_W-1:0] store_code;
  logic [Y_W-1:0]   store_y;

`ifdef ADC_AVG_EN
  // Four conversions per channel; 4 x 511 fits in 11 bits.
  localparam int N_AVG = 4;
  localparam int ACC_W = 11;

  logic [ACC_W-1:0] acc_q;
  logic [1:0]       conv_q;

  assign store_code = acc_q[ACC_W-1:2];
`else
  logic [ADC_W-1:0] code_q;

  assign store_code = code_q;
`endif

  assign store_y = clamp_y(store_code, Y_LIM);

  // Free-running scan period counter; its wrap cycle is the scan tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
    end else if (tick) begin
      period_q <= '0;
    end else begin
      period_q <= period_q + 1'b1;
    end
  end

  assign tick = (period_q == PERIOD_LAST);

  // Settle timer: preloaded outside SETTLE so it expires after exactly SETTLE_CYC cycles there.
  cyc_timer #(.W(SW)) u_settle_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q != ST_SETTLE),
    .load_val_i (SETTLE_LOAD),
    .zero_o     (settle_done)
  );

  // Conversion timeout: preloaded in START, expires on the TIMEOUT_CYC-th WAIT cycle.
  cyc_timer #(.W(TW)) u_wait_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q != ST_WAIT),
    .load_val_i (TIMEOUT_LOAD),
    .zero_o     (wait_expired)
  );

  // Scan sequencer: channel 0 then 1 through settle, convert, store; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= 1'b0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      p1_q    <= DEFAULT_Y;
      p2_q    <= DEFAULT_Y;
`ifdef ADC_AVG_EN
      acc_q   <= '0;
      conv_q  <= '0;
`else
      code_q  <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      upd_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick && en) begin
            state_q <= ST_SETTLE;
            ch_q    <= 1'b0;
            sel_q   <= 1'b0;
          end
        end

        ST_SETTLE: begin
`ifdef ADC_AVG_EN
          acc_q  <= '0;
          conv_q <= '0;
`endif
          if (settle_done) begin
            state_q <= ST_START;
            start_q <= 1'b1;
          end
        end

        ST_START: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // A done on the last WAIT cycle still counts; only silence times out.
          if (adc_done) begin
`ifdef ADC_AVG_EN
            acc_q  <= acc_q + ACC_W'(adc_data);
            conv_q <= conv_q + 1'b1;
            if (conv_q == 2'(N_AVG - 1)) begin
              state_q <= ST_STORE;
            end else begin
              state_q <= ST_START;
              start_q <= 1'b1;
            end
`else
            code_q  <= adc_data;
            state_q <= ST_STORE;
`endif
          end else if (wait_expired) begin
            // Abandon this channel without touching its Y, then carry on as after a store.
            err_q <= 1'b1;
            if (!ch_q) begin
              state_q <= ST_SETTLE;
              ch_q    <= 1'b1;
              sel_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              upd_q   <= 1'b1;
            end
          end
        end

        ST_STORE: begin
          if (!ch_q) begin
            p1_q <= store_y;
          end else begin
            p2_q <= store_y;
          end
          if (!ch_q) begin
            state_q <= ST_SETTLE;
            ch_q    <= 1'b1;
            sel_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            upd_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign adc_start   = start_q;
  assign p1_y        = p1_q;
  assign p2_y        = p2_q;
  assign upd         = upd_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: randomized and directed stimulus against a cycle-schedule model of the scan controller.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_adc_scan_ctrl;

  localparam int S  = 4;
  localparam int TO = 16;
  localparam int P  = 64;
  localparam int YM = 479;
`ifdef ADC_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  // tick->upd with every conversion answered 3 cycles after its start pulse
  localparam int LAT3 = 2 * (S + NCONV * (1 + 3) + 1) + 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b0;
  logic       adc_done = 1'b0;
  logic [8:0] adc_data = '0;
  logic       sel, adc_start, upd, timeout_err;
  logic [9:0] p1_y, p2_y;

  int checks = 0;
  int failures = 0;

  // reference model: absolute cycle schedule of the current scan
  int k, busy, ch, sel_e, err_e;
  int start_cyc, upd_cyc, resp_cyc, wait_end, store_cyc, wait_active, resp_code;
  int p_e[2];
  int codes[$];

  // stimulus knobs
  int en_cfg, fixed_d, drop_ch1, rand_drop, spur, rand_codes, dir_inc;
  int dir_code[2];

  // observations of the DUT
  int starts_total, starts_cnt, starts_per_scan, upd_seen, last_tick, lat;

  adc_scan_ctrl #(
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (TO),
    .SCAN_PERIOD (P),
    .Y_MAX       (YM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .adc_data    (adc_data),
    .adc_done    (adc_done),
    .sel         (sel),
    .adc_start   (adc_start),
    .p1_y        (p1_y),
    .p2_y        (p2_y),
    .upd         (upd),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; busy = 0; ch = 0; sel_e = 0; err_e = 0;
    start_cyc = -1; upd_cyc = -1; resp_cyc = -1; wait_end = -1; store_cyc = -1;
    wait_active = 0; resp_code = 0;
    p_e[0] = 240; p_e[1] = 240;
    codes.delete();
    starts_cnt = 0;
  endtask

  // A channel finished at cycle e (stored or abandoned).
  task automatic chan_end(input int e);
    if (ch == 0) begin
      ch = 1;
      sel_e = 1;
      codes.delete();
      start_cyc = e + S + 1;
    end else begin
      busy = 0;
      upd_cyc = e + 1;
    end
  endtask

  // One clock cycle: compare outputs, drive inputs for this cycle, advance the model past its edge.
  task automatic step(input bit r);
    int d, sum, y, was_busy;
    bit drop;
    @(negedge clk);
    chk("sel", sel, sel_e);
    chk("adc_start", adc_start, int'(k == start_cyc));
    chk("upd", upd, int'(k == upd_cyc));
    chk("p1_y", p1_y, p_e[0]);
    chk("p2_y", p2_y, p_e[1]);
    chk("timeout_err", timeout_err, err_e);

    if (adc_start) begin
      starts_total++;
      starts_cnt++;
    end
    if (upd) begin
      upd_seen++;
      starts_per_scan = starts_cnt;
      starts_cnt = 0;
      lat = k - last_tick;
    end

    rst = r;
    en = (en_cfg != 0);
    adc_done = 1'b0;
    adc_data = 9'($urandom_range(0, 511));
    if (wait_active != 0 && k == resp_cyc) begin
      adc_done = 1'b1;
      adc_data = 9'(resp_code);
    end else if (spur != 0 && wait_active == 0 && $urandom_range(0, 3) == 0) begin
      adc_done = 1'b1;
    end

    if (r) begin
      model_reset();
      return;
    end

    was_busy = busy;
    if (k == start_cyc) begin
      d = (fixed_d != 0) ? fixed_d : int'($urandom_range(1, TO));
      drop = (ch == 1 && drop_ch1 != 0) || (rand_drop != 0 && $urandom_range(0, 7) == 0);
      resp_cyc = drop ? -1 : k + d;
      resp_code = (rand_codes != 0) ? int'($urandom_range(0, 511))
                                    : dir_code[ch] + dir_inc * codes.size();
      wait_end = k + TO;
      wait_active = 1;
    end else if (wait_active != 0 && k == resp_cyc) begin
      wait_active = 0;
      codes.push_back(resp_code);
      if (codes.size() == NCONV) store_cyc = k + 1;
      else start_cyc = k + 1;
    end else if (wait_active != 0 && k == wait_end) begin
      wait_active = 0;
      err_e = 1;
      chan_end(k);
    end else if (k == store_cyc) begin
      sum = 0;
      foreach (codes[i]) sum += codes[i];
      y = sum / NCONV;
      p_e[ch] = (y > YM) ? YM : y;
      chan_end(k);
    end

    if (was_busy == 0 && (k % P) == P - 1 && en_cfg != 0) begin
      busy = 1;
      ch = 0;
      sel_e = 0;
      codes.delete();
      start_cyc = k + S + 1;
      last_tick = k;
    end
    k++;
  endtask

  task automatic wait_upd(input string name);
    int u0;
    u0 = upd_seen;
    for (int i = 0; i < 400 && upd_seen == u0; i++) step(1'b0);
    chk(name, int'(upd_seen > u0), 1);
  endtask

  initial begin
    int n;
    model_reset();
    starts_total = 0; starts_per_scan = 0; upd_seen = 0; last_tick = 0; lat = 0;
    en_cfg = 0; fixed_d = 3; drop_ch1 = 0; rand_drop = 0; spur = 0; rand_codes = 0; dir_inc = 0;
    dir_code[0] = 0; dir_code[1] = 0;

    // reset, then idle with en low
    step(1'b1);
    step(1'b1);
    repeat (200) step(1'b0);
    chk("idle_p1", p1_y, 240);
    chk("idle_p2", p2_y, 240);
    chk("idle_sel", sel, 0);
    chk("idle_starts", starts_total, 0);

    // two plain scans: codes 100/300, done 3 cycles after start
    dir_code[0] = 100; dir_code[1] = 300; en_cfg = 1;
    wait_upd("upd_scan1");
    chk("scan1_p1", p1_y, 100);
    chk("scan1_p2", p2_y, 300);
    chk("scan1_starts", starts_per_scan, 2 * NCONV);
    chk("scan1_latency", lat, LAT3);
    chk("model_p1", p_e[0], 100);
    wait_upd("upd_scan2");
    chk("scan2_starts", starts_per_scan, 2 * NCONV);

    // clamp region
    dir_code[0] = 511; dir_code[1] = 480;
    wait_upd("upd_clamp");
    chk("clamp_p1", p1_y, 479);
    chk("clamp_p2", p2_y, 479);
    dir_code[0] = 479; dir_code[1] = 0;
    wait_upd("upd_edge");
    chk("edge_p1", p1_y, 479);
    chk("edge_p2", p2_y, 0);

    // channel 1 never answers
    dir_code[0] = 200; dir_code[1] = 333; drop_ch1 = 1;
    wait_upd("upd_timeout");
    chk("to_p1", p1_y, 200);
    chk("to_p2_kept", p2_y, 0);
    chk("to_err", timeout_err, 1);
    drop_ch1 = 0; dir_code[0] = 50; dir_code[1] = 60;
    wait_upd("upd_after_to");
    chk("after_to_p1", p1_y, 50);
    chk("after_to_p2", p2_y, 60);
    chk("err_sticky", timeout_err, 1);

    // spurious done outside WAIT
    spur = 1; dir_code[0] = 7; dir_code[1] = 8;
    wait_upd("upd_spur");
    chk("spur_p1", p1_y, 7);
    chk("spur_p2", p2_y, 8);

    // averaging (or single-code) pattern with distinct codes per conversion
    spur = 0; dir_inc = 1; dir_code[0] = 100; dir_code[1] = 300;
    wait_upd("upd_avg");
`ifdef ADC_AVG_EN
    chk("avg_p1", p1_y, 101);
    chk("avg_p2", p2_y, 301);
`else
    chk("avg_p1", p1_y, 100);
    chk("avg_p2", p2_y, 300);
`endif
    chk("avg_starts", starts_per_scan, 2 * NCONV);
    dir_inc = 0;

    // reset in the middle of a WAIT
    n = 0;
    while (wait_active == 0 && n < 300) begin
      step(1'b0);
      n++;
    end
    chk("reach_wait", wait_active, 1);
    step(1'b1);
    step(1'b0);
    chk("rst_p1", p1_y, 240);
    chk("rst_p2", p2_y, 240);
    chk("rst_err", timeout_err, 0);
    chk("rst_sel", sel, 0);

    // randomized codes, delays, drops, spurious dones and en toggling
    rand_codes = 1; fixed_d = 0; rand_drop = 1; spur = 1;
    for (int blk = 0; blk < 30; blk++) begin
      en_cfg = ($urandom_range(0, 4) != 0) ? 1 : 0;
      repeat ($urandom_range(20, 90)) step(1'b0);
    end
    en_cfg = 0;
    repeat (200) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
